// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file : RV32I integer register file (x0..x31, x0 hard-wired to zero).
//
// Two combinational read ports and one synchronous write port. The file sits
// directly upstream of the ALU: rd1 drives ALU r1, and rd2 drives ALU r2 ahead
// of the immediate mux. Write-back data is selected in the datapath before it
// reaches this block.
//
// Ports
//   clk    in   1     core clock; all register updates on the rising edge
//   rst_n  in   1     asynchronous active-low reset; clears x1..x31
//   rs1    in   AW    read address, port 1
//   rs2    in   AW    read address, port 2
//   rd     in   AW    write address
//   we     in   1     write enable, sampled at the rising edge of clk
//   wd     in   XLEN  write data
//   rd1    out  XLEN  read data for rs1 (combinational)
//   rd2    out  XLEN  read data for rs2 (combinational)
//
// Build option
//   RF_BYPASS_EN  When defined, a write that is in progress is forwarded to a
//                 read port whose address matches rd, in the same cycle. This
//                 is meant for a future pipelined core. x0 still reads 0.
//                 When undefined, the read ports show stored contents only.
// -----------------------------------------------------------------------------
module reg_file #(
   parameter  int unsigned XLEN = 32,
   parameter  int unsigned NREG = 32,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic [AW-1:0]   rd,
   input  logic            we,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   // Only x1..x(NREG-1) are stored. x0 has no flop.
   logic [XLEN-1:0] regs [1:NREG-1];

   // A write to x0 is a legal no-op, so it is folded into the enable.
   logic wr_act;
   assign wr_act = we && (rd != '0);

   // Storage. Reset clears all registers at once and wins over a pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_act) begin
         for (int unsigned i = 1; i < NREG; i++) begin
            if (rd == AW'(i)) begin
               regs[i] <= wd;
            end
         end
      end
   end

   // Read port 1. The mux defaults to zero, so an address of 0, or one that
   // falls beyond the register count, reads 0 and never X.
   always_comb begin
      rd1 = '0;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (rs1 == AW'(i)) begin
            rd1 = regs[i];
         end
      end
`ifdef RF_BYPASS_EN
      if (wr_act && (rd == rs1)) begin
         rd1 = wd;
      end
`endif
   end

   // Read port 2 uses the same structure as port 1.
   always_comb begin
      rd2 = '0;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (rs2 == AW'(i)) begin
            rd2 = regs[i];
         end
      end
`ifdef RF_BYPASS_EN
      if (wr_act && (rd == rs2)) begin
         rd2 = wd;
      end
`endif
   end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file : self-checking bench for reg_file.
//
// Table-driven write/read vectors come first, followed by hand-written
// sequences for reset and same-cycle collisions. Every expected read pair is
// queued when its stimulus is driven, then popped and compared against rd1/rd2.
// -----------------------------------------------------------------------------
module tb_reg_file;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic            clk;
   logic            rst_n;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [AW-1:0]   rd;
   logic            we;
   logic [XLEN-1:0] wd;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;

   logic            run;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic            we;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] wd;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [XLEN-1:0] exp1;
      logic [XLEN-1:0] exp2;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0] e1;
      logic [XLEN-1:0] e2;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[10];

   reg_file dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rs1   (rs1),
      .rs2   (rs2),
      .rd    (rd),
      .we    (we),
      .wd    (wd),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   // Gated clock, so that reset can be exercised with no clock running.
   initial clk = 1'b0;
   always begin
      #5;
      if (run) clk = ~clk;
   end

   // Watchdog against any hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
      exp_t e;
      e.e1 = e1;
      e.e2 = e2;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got none want entry", name);
      end else begin
         e = sb.pop_front();
         check({name, ".rd1"}, rd1, e.e1);
         check({name, ".rd2"}, rd2, e.e2);
      end
   endtask

   task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      we = 1'b1;
      rd = a;
      wd = d;
      tick();
      we = 1'b0;
   endtask

   initial begin
      run   = 1'b1;
      rst_n = 1'b0;
      we    = 1'b0;
      rd    = '0;
      wd    = '0;
      rs1   = 5'd5;
      rs2   = 5'd31;

      // Each vector: drive a write, clock once, then read rs1/rs2.
      vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 5'd0,  32'h00000000, 5'd6,  5'd8,  32'h0,        32'h0};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd0,  32'h12345678, 32'h0};
      vecs[4] = '{1'b0, 5'd3,  32'h00000000, 5'd3,  5'd7,  32'h12345678, 32'hDEADBEEF};
      vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0};
      vecs[6] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hA5A5A5A5};
      vecs[7] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h00000001};
      vecs[8] = '{1'b1, 5'd5,  32'h0BADF00D, 5'd5,  5'd6,  32'h0BADF00D, 32'h0};
      vecs[9] = '{1'b1, 5'd7,  32'h00000000, 5'd7,  5'd3,  32'h0,        32'h12345678};

      // Power-on reset. Outputs must read 0 while reset is held.
      repeat (3) tick();
      push_exp(32'h0, 32'h0);
      pop_check("reset_hold");
      rst_n = 1'b1;
      tick();
      push_exp(32'h0, 32'h0);
      pop_check("after_reset");

      // Table-driven vectors.
      for (int i = 0; i < 10; i++) begin
         we  = vecs[i].we;
         rd  = vecs[i].rd;
         wd  = vecs[i].wd;
         rs1 = vecs[i].rs1;
         rs2 = vecs[i].rs2;
         push_exp(vecs[i].exp1, vecs[i].exp2);
         tick();
         we = 1'b0;
         #1;
         pop_check($sformatf("vec%0d", i));
      end

      // Same-cycle collision on x10. The read is sampled before the edge.
      write_reg(5'd10, 32'h1);
      we  = 1'b1;
      rd  = 5'd10;
      wd  = 32'h2;
      rs1 = 5'd10;
      rs2 = 5'd0;
`ifdef RF_BYPASS_EN
      push_exp(32'h2, 32'h0);
`else
      push_exp(32'h1, 32'h0);
`endif
      #1;
      pop_check("collide_pre");
      push_exp(32'h2, 32'h0);
      tick();
      we = 1'b0;
      pop_check("collide_post");

      // A write to x0 must not forward, even if bypass is built in.
      we  = 1'b1;
      rd  = 5'd0;
      wd  = 32'hFFFFFFFF;
      rs1 = 5'd0;
      rs2 = 5'd0;
      push_exp(32'h0, 32'h0);
      #1;
      pop_check("x0_write_pre");
      tick();
      we = 1'b0;

      // Reset asserted during a write. Reset wins and the write is lost.
      write_reg(5'd12, 32'h5555AAAA);
      rs1 = 5'd12;
      rs2 = 5'd10;
      @(negedge clk);
      we    = 1'b1;
      rd    = 5'd12;
      wd    = 32'hFFFF0000;
      rst_n = 1'b0;
      tick();
      we = 1'b0;
      push_exp(32'h0, 32'h0);
      pop_check("reset_during_write");
      rst_n = 1'b1;
      tick();

      // Asynchronous reset with the clock stopped.
      write_reg(5'd5, 32'hCAFEF00D);
      write_reg(5'd31, 32'h87654321);
      rs1 = 5'd5;
      rs2 = 5'd31;
      push_exp(32'hCAFEF00D, 32'h87654321);
      #1;
      pop_check("pre_async_reset");
      @(negedge clk);
      run = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      push_exp(32'h0, 32'h0);
      pop_check("async_reset_noclk");
      #10;
      rst_n = 1'b1;
      #2;
      run = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         push_exp(32'h0, 32'h0);
         #1;
         pop_check($sformatf("post_reset_x%0d", i));
      end

      // Walk every writable register, then read back complementary pairs.
      for (int i = 1; i < 32; i++) begin
         write_reg(5'(i), 32'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         push_exp(32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101);
         #1;
         pop_check($sformatf("walk_x%0d", i));
      end

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
